// File: rtl/mac_cmd_feeder_if.sv
// Host command channel into the MAC command feeder: valid/ready handshake
// carrying one instruction code and two 16-bit operands.
interface mac_cmd_feeder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_instr;
    logic [15:0] cmd_mplier;
    logic [15:0] cmd_mcand;

    modport master (output cmd_valid, cmd_instr, cmd_mplier, cmd_mcand, input cmd_ready);
    modport slave  (input cmd_valid, cmd_instr, cmd_mplier, cmd_mcand, output cmd_ready);
endinterface

// File: rtl/mac_cmd_feeder.sv
// Command FIFO + issue FSM feeding a 16x16 MAC one instruction per clock.
// Optional: `define MAC_CLR_ON_START_EN inserts a clear instruction at the start of each burst.
module mac_cmd_feeder #(
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    mac_cmd_feeder_if.slave   cmd,
    input  logic              hold,
    input  logic              out_ready,
    output logic [2:0]        instruction,
    output logic [15:0]       multiplier,
    output logic [15:0]       multiplicand,
    output logic              stall,
    output logic              busy,
    output logic              flush_done,
    output logic [AW:0]       level,
    output logic [15:0]       issued_cnt
);

    localparam int          CW        = $clog2(DRAIN_CYC + 1);
    localparam logic [AW:0] FULL      = (AW + 1)'(DEPTH);
    localparam logic [2:0]  NOP_INSTR = 3'b010;
    localparam logic [2:0]  CLR_INSTR = 3'b000;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [2:0]  instr;
        logic [15:0] mplier;
        logic [15:0] mcand;
    } cmd_t;

    cmd_t          mem [DEPTH];
    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic [CW-1:0] drain_cnt;
    logic          push;
    logic          pop;
    logic          clr_now;

    assign cmd.cmd_ready = (level != FULL);
    assign busy          = (state != IDLE);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

`ifdef MAC_CLR_ON_START_EN
    logic clr_pend;

    // The clear occupies the first issue slot of a burst, so popping waits behind it.
    assign clr_now = clr_pend && (state == ISSUE) && !hold && out_ready;
    assign pop     = (state == ISSUE) && (level != '0) && !hold && out_ready && !clr_pend;
`else
    assign clr_now = 1'b0;
    assign pop     = (state == ISSUE) && (level != '0) && !hold && out_ready;
`endif

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + (AW + 1)'(1);
        else if (pop && !push)
            level_nxt = level - (AW + 1)'(1);
    end

    // Payload storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{instr: cmd.cmd_instr, mplier: cmd.cmd_mplier, mcand: cmd.cmd_mcand};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            drain_cnt    <= '0;
            instruction  <= NOP_INSTR;
            multiplier   <= '0;
            multiplicand <= '0;
            stall        <= 1'b1;
            flush_done   <= 1'b0;
            issued_cnt   <= '0;
`ifdef MAC_CLR_ON_START_EN
            clr_pend     <= 1'b0;
`endif
        end else begin
            stall      <= ~out_ready;
            flush_done <= 1'b0;
            level      <= level_nxt;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                instruction  <= mem[rd_ptr].instr;
                multiplier   <= mem[rd_ptr].mplier;
                multiplicand <= mem[rd_ptr].mcand;
                issued_cnt   <= issued_cnt + 16'd1;
            end else begin
                instruction  <= clr_now ? CLR_INSTR : NOP_INSTR;
                multiplier   <= '0;
                multiplicand <= '0;
            end

`ifdef MAC_CLR_ON_START_EN
            if (clr_now)
                clr_pend <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (level != '0) begin
                        state <= ISSUE;
`ifdef MAC_CLR_ON_START_EN
                        clr_pend <= 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    if (level_nxt == '0) begin
                        state     <= DRAIN;
                        drain_cnt <= CW'(DRAIN_CYC);
                    end
                end
                DRAIN: begin
                    // A fresh command outranks drain completion: resume issuing, no flush pulse.
                    if (push) begin
                        state <= ISSUE;
                    end else if (out_ready) begin
                        if (drain_cnt == CW'(1)) begin
                            state      <= IDLE;
                            flush_done <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_cmd_feeder.sv
// Directed self-checking bench for mac_cmd_feeder; expectations follow the
// optional clear-on-start build when MAC_CLR_ON_START_EN is defined.
module tb_mac_cmd_feeder;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DRAIN_CYC = 2;
`ifdef MAC_CLR_ON_START_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif
    localparam logic [34:0] NOP_W = {3'b010, 16'h0000, 16'h0000};
    localparam logic [34:0] CLR_W = {3'b000, 16'h0000, 16'h0000};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hold;
    logic        out_ready;
    logic [2:0]  instruction;
    logic [15:0] multiplier;
    logic [15:0] multiplicand;
    logic        stall;
    logic        busy;
    logic        flush_done;
    logic [AW:0] level;
    logic [15:0] issued_cnt;
    logic [34:0] word;

    int n_cmp = 0;
    int n_err = 0;

    mac_cmd_feeder_if cif();

    mac_cmd_feeder #(.DEPTH(DEPTH), .AW(AW), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd          (cif),
        .hold         (hold),
        .out_ready    (out_ready),
        .instruction  (instruction),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .stall        (stall),
        .busy         (busy),
        .flush_done   (flush_done),
        .level        (level),
        .issued_cnt   (issued_cnt)
    );

    assign word = {instruction, multiplier, multiplicand};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic push_cmd(input logic [34:0] c);
        cif.cmd_valid  = 1'b1;
        cif.cmd_instr  = c[34:32];
        cif.cmd_mplier = c[31:16];
        cif.cmd_mcand  = c[15:0];
        @(negedge clk);
        cif.cmd_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_idle: busy=%b required 0 within 40 cycles", tag, busy); end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++; if (word !== NOP_W) begin n_err++; $display("FAIL rst_word: got %h required %h", word, NOP_W); end
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b required 1", stall); end
        n_cmp++; if ({busy, flush_done} !== 2'b00) begin n_err++; $display("FAIL rst_busy_flush: got %b required 00", {busy, flush_done}); end
        n_cmp++; if ({level, issued_cnt} !== 19'd0) begin n_err++; $display("FAIL rst_level_cnt: got %0d/%0d required 0/0", level, issued_cnt); end
        n_cmp++; if (cif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b required 1", cif.cmd_ready); end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_release: got %b required 0", stall); end
    endtask

    task automatic test_single;
        push_cmd({3'b001, 16'h0003, 16'hFFFE});
        n_cmp++; if ({level, busy} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL single_queued: level/busy %0d/%b required 1/0", level, busy); end
        repeat (2 + CLR) @(negedge clk);
        n_cmp++; if (word !== {3'b001, 16'h0003, 16'hFFFE}) begin n_err++; $display("FAIL single_word: got %h required %h", word, {3'b001, 16'h0003, 16'hFFFE}); end
        n_cmp++; if ({level, issued_cnt} !== {3'd0, 16'd1}) begin n_err++; $display("FAIL single_cnt: level/cnt %0d/%0d required 0/1", level, issued_cnt); end
        @(negedge clk);
        n_cmp++; if ({word, busy, flush_done} !== {NOP_W, 2'b10}) begin n_err++; $display("FAIL single_drain1: word %h busy %b flush %b required %h 1 0", word, busy, flush_done, NOP_W); end
        @(negedge clk);
        n_cmp++; if ({word, busy, flush_done} !== {NOP_W, 2'b01}) begin n_err++; $display("FAIL single_flush: word %h busy %b flush %b required %h 0 1", word, busy, flush_done, NOP_W); end
        n_cmp++; if (issued_cnt !== 16'd1) begin n_err++; $display("FAIL single_issued: got %0d required 1", issued_cnt); end
        @(negedge clk);
        n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL single_flush_pulse: got %b required 0", flush_done); end
    endtask

    task automatic test_full;
        logic [34:0] fc [5];
        fc[0] = {3'b001, 16'h1111, 16'h2222};
        fc[1] = {3'b011, 16'h3333, 16'h4444};
        fc[2] = {3'b100, 16'h5555, 16'h6666};
        fc[3] = {3'b101, 16'h7777, 16'h8888};
        fc[4] = {3'b110, 16'h9999, 16'hAAAA};
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cif.cmd_valid  = 1'b1;
            cif.cmd_instr  = fc[i][34:32];
            cif.cmd_mplier = fc[i][31:16];
            cif.cmd_mcand  = fc[i][15:0];
            n_cmp++; if (cif.cmd_ready !== (i < 4)) begin n_err++; $display("FAIL full_ready%0d: got %b required %b", i, cif.cmd_ready, (i < 4)); end
            @(negedge clk);
        end
        cif.cmd_valid = 1'b0;
        n_cmp++; if ({level, cif.cmd_ready, busy} !== {3'd4, 1'b0, 1'b1}) begin n_err++; $display("FAIL full_level: level/ready/busy %0d/%b/%b required 4/0/1", level, cif.cmd_ready, busy); end
        n_cmp++; if ({word, issued_cnt} !== {NOP_W, 16'd1}) begin n_err++; $display("FAIL full_hold_nop: word %h cnt %0d required %h 1", word, issued_cnt, NOP_W); end
        hold = 1'b0;
        repeat (1 + CLR) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if ({word, issued_cnt} !== {fc[k], 16'(2 + k)}) begin n_err++; $display("FAIL full_pop%0d: word %h cnt %0d required %h %0d", k, word, issued_cnt, fc[k], 2 + k); end
            if (k < 3) @(negedge clk);
        end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL full_empty: level %0d required 0", level); end
        wait_idle("full");
        n_cmp++; if (issued_cnt !== 16'd5) begin n_err++; $display("FAIL full_total: got %0d required 5", issued_cnt); end
    endtask

    task automatic test_backpressure;
        logic [34:0] bc [4];
        bc[0] = {3'b001, 16'h0101, 16'h0202};
        bc[1] = {3'b011, 16'h0303, 16'h0404};
        bc[2] = {3'b101, 16'h0505, 16'h0606};
        bc[3] = {3'b111, 16'h0707, 16'h0808};
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(bc[i]);
        hold = 1'b0;
        repeat (1 + CLR) @(negedge clk);
        n_cmp++; if ({word, stall, issued_cnt} !== {bc[0], 1'b0, 16'd6}) begin n_err++; $display("FAIL bp_first: word %h stall %b cnt %0d required %h 0 6", word, stall, issued_cnt, bc[0]); end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({word, stall, level} !== {NOP_W, 1'b1, 3'd3}) begin n_err++; $display("FAIL bp_stall%0d: word %h stall %b level %0d required %h 1 3", c, word, stall, level, NOP_W); end
        end
        out_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            n_cmp++; if ({word, stall, issued_cnt} !== {bc[j], 1'b0, 16'(6 + j)}) begin n_err++; $display("FAIL bp_resume%0d: word %h stall %b cnt %0d required %h 0 %0d", j, word, stall, issued_cnt, bc[j], 6 + j); end
        end
        wait_idle("bp");
    endtask

    task automatic test_drain_abort;
        push_cmd({3'b001, 16'hABCD, 16'h0011});
        repeat (2 + CLR) @(negedge clk);
        n_cmp++; if ({word, issued_cnt} !== {3'b001, 16'hABCD, 16'h0011, 16'd10}) begin n_err++; $display("FAIL abort_first: word %h cnt %0d required %h 10", word, issued_cnt, {3'b001, 16'hABCD, 16'h0011}); end
        push_cmd({3'b100, 16'h1234, 16'h5678});
        n_cmp++; if ({word, level, busy, flush_done} !== {NOP_W, 3'd1, 2'b10}) begin n_err++; $display("FAIL abort_reissue: word %h level %0d busy %b flush %b required %h 1 1 0", word, level, busy, flush_done, NOP_W); end
        @(negedge clk);
        n_cmp++; if ({word, issued_cnt, flush_done} !== {3'b100, 16'h1234, 16'h5678, 16'd11, 1'b0}) begin n_err++; $display("FAIL abort_second: word %h cnt %0d flush %b required %h 11 0", word, issued_cnt, flush_done, {3'b100, 16'h1234, 16'h5678}); end
        @(negedge clk);
        n_cmp++; if ({busy, flush_done} !== 2'b10) begin n_err++; $display("FAIL abort_drain: busy/flush %b required 10", {busy, flush_done}); end
        @(negedge clk);
        n_cmp++; if ({busy, flush_done} !== 2'b01) begin n_err++; $display("FAIL abort_flush: busy/flush %b required 01", {busy, flush_done}); end
    endtask

    task automatic test_bursts;
        logic [34:0] ec [2];
        ec[0] = {3'b011, 16'h00AA, 16'h00BB};
        ec[1] = {3'b101, 16'h00CC, 16'h00DD};
        for (int b = 0; b < 2; b++) begin
            push_cmd(ec[b]);
            repeat (2) @(negedge clk);
`ifdef MAC_CLR_ON_START_EN
            n_cmp++; if ({word, issued_cnt} !== {CLR_W, 16'(11 + b)}) begin n_err++; $display("FAIL burst%0d_clear: word %h cnt %0d required %h %0d", b, word, issued_cnt, CLR_W, 11 + b); end
            @(negedge clk);
`endif
            n_cmp++; if ({word, issued_cnt} !== {ec[b], 16'(12 + b)}) begin n_err++; $display("FAIL burst%0d_head: word %h cnt %0d required %h %0d", b, word, issued_cnt, ec[b], 12 + b); end
            wait_idle("burst");
        end
    endtask

    task automatic test_reset_mid;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd({3'b001, 16'(i + 1), 16'h0F0F});
        n_cmp++; if ({level, busy, stall, issued_cnt} !== {3'd3, 2'b10, 16'd13}) begin n_err++; $display("FAIL midrst_pre: level %0d busy %b stall %b cnt %0d required 3 1 0 13", level, busy, stall, issued_cnt); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({level, issued_cnt} !== 19'd0) begin n_err++; $display("FAIL midrst_clear: level/cnt %0d/%0d required 0/0", level, issued_cnt); end
        n_cmp++; if ({word, stall, busy, flush_done} !== {NOP_W, 3'b100}) begin n_err++; $display("FAIL midrst_outs: word %h stall %b busy %b flush %b required %h 1 0 0", word, stall, busy, flush_done, NOP_W); end
        @(negedge clk);
        reset_n = 1'b1;
        hold = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if ({level, busy, word, issued_cnt} !== {3'd0, 1'b0, NOP_W, 16'd0}) begin n_err++; $display("FAIL midrst_discard: level %0d busy %b word %h cnt %0d required 0 0 %h 0", level, busy, word, issued_cnt, NOP_W); end
    endtask

    initial begin
        reset_n        = 1'b0;
        hold           = 1'b0;
        out_ready      = 1'b1;
        cif.cmd_valid  = 1'b0;
        cif.cmd_instr  = 3'b000;
        cif.cmd_mplier = 16'h0000;
        cif.cmd_mcand  = 16'h0000;
        test_reset();
        test_single();
        test_full();
        test_backpressure();
        test_drain_abort();
        test_bursts();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac_cmd_feeder.md
Name: mac_cmd_feeder

Overview:
- Upstream stage of the 16x16 MAC unit. Buffers host commands (instruction, multiplier, multiplicand) in a small FIFO and issues exactly one MAC instruction per clock.
- The MAC executes its instruction input on every cycle. The feeder therefore inserts zero-operand NOPs whenever no real command may issue, and drives the MAC stall input from downstream backpressure.
- After the last queued command it runs a drain sequence so the MAC's 2-deep output queue flushes.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2).
- AW, 2, log2(DEPTH).
- DRAIN_CYC, 2, NOP cycles issued after the FIFO empties, to flush the MAC output queue.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset; asynchronous and active-low.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept; equals (level != DEPTH).
- cmd_instr  in  3  MAC instruction code.
- cmd_mplier  in  16  multiplier operand.
- cmd_mcand  in  16  multiplicand operand.
- hold  in  1  upstream pause; no pops while high.
- out_ready  in  1  downstream result consumer ready.
- instruction  out  3  to MAC instruction (registered).
- multiplier  out  16  to MAC (registered).
- multiplicand  out  16  to MAC (registered).
- stall  out  1  to MAC stall (registered).
- busy  out  1  state != IDLE.
- flush_done  out  1  one-cycle pulse at DRAIN->IDLE.
- level  out  AW+1  FIFO occupancy.
- issued_cnt  out  16  count of real (non-NOP) commands issued; wraps at 16'hFFFF->0.

Behaviour:
- Reset (async, reset_n=0):
  - instruction=3'b010, multiplier=0, multiplicand=0 (NOP).
  - stall=1, busy=0, flush_done=0, level=0, issued_cnt=0.
  - FIFO pointers cleared, state=IDLE.
  - Reset mid-operation discards all queued commands.
- NOP encoding: instruction=3'b010 with both operands 0. It adds zero and leaves the accumulator intact.
- Push: cmd_valid && cmd_ready writes the tail entry.
- Pop condition: state==ISSUE && level!=0 && !hold && out_ready.
- Simultaneous push and pop:
  - level unchanged.
  - Allowed when full: cmd_ready is still 0 when full, so no push is accepted that cycle.
  - Allowed when empty: a pushed entry is not poppable until the next cycle (no bypass).
- Output registers:
  - On pop, load the head entry into instruction/multiplier/multiplicand the next edge, and increment issued_cnt.
  - Otherwise load the NOP.
  - Latency: a command pushed into an empty FIFO in ISSUE reaches the MAC inputs 2 cycles later.
- stall register: loads ~out_ready every cycle, in every state. While stall=1, no real command is ever issued, so no MAC result is lost.
- FSM:
  - IDLE: go to ISSUE when level!=0.
  - ISSUE: go to DRAIN when level==0 after a pop, or when level==0 and no push this cycle. Load drain counter = DRAIN_CYC.
  - DRAIN: issue NOPs. Counter decrements only in cycles with out_ready=1. At counter==1 with out_ready=1, go to IDLE and pulse flush_done.
  - DRAIN with push: if a push arrives during DRAIN, abort the drain and return to ISSUE the next cycle (no flush_done).
- hold=1 in ISSUE issues NOPs. The FSM stays in ISSUE even if level>0.
- pointers wrap modulo DEPTH; level saturates nowhere (bounded by cmd_ready).

Optional Feature:
- MAC_CLR_ON_START_EN defined:
  - On every IDLE->ISSUE transition, the first issued cycle is instruction=3'b000 (clear), operands 0. It is not counted in issued_cnt and does not pop.
  - Popping begins the following cycle.
- Undefined: no clear is inserted; the accumulator carries over between bursts.

Test Plan:
- Reset: assert reset_n=0 mid-burst with level=3 -> immediately level=0, instruction=3'b010, operands 0, stall=1, busy=0, issued_cnt=0.
- Single command: push {001,16'h0003,16'hFFFE} into empty FIFO, out_ready=1 -> MAC inputs show it 2 cycles later. Then 2 NOP cycles, then flush_done pulses, busy=0, issued_cnt=1.
- Full FIFO: push 5 commands back-to-back with hold=1 -> cmd_ready=0 after 4th, level=4, 5th not accepted. Release hold -> 4 pops on consecutive cycles, issued_cnt=4.
- Backpressure: out_ready=0 for 3 cycles during a burst -> stall=1 one cycle later, only NOPs issued, no pops. out_ready=1 resumes in-order issue with no loss or duplication.
- Drain abort: push a new command during DRAIN cycle 1 -> returns to ISSUE, command issued, no flush_done until the subsequent full drain.
- MAC_CLR_ON_START_EN: two bursts separated by IDLE -> each burst's first issued instruction is 3'b000. Without the macro, the first issued instruction is the head command.
